// File: rtl/data_bus_responder_if.sv
// rtl/data_bus_responder_if.sv - core data-RAM port and output byte stream bundle
//
// Purpose: groups the core's data-RAM access port and the encoded-stream
//          valid/ready handshake into one bundle.
// Signals:
//   writeram      core -> responder  store strobe
//   ramaddress    core -> responder  byte address
//   writeramdata  core -> responder  store data
//   readramdata   responder -> core  load data (combinational)
//   stream_data   responder -> sink  FIFO head byte
//   stream_valid  responder -> sink  FIFO not empty
//   stream_ready  sink -> responder  sink accepts head byte
// Modports: slave = responder side, master = core/sink side.
`timescale 1ns/1ps

interface data_bus_responder_if #(
  parameter int WIDTH = 32
);
  logic             writeram;
  logic [WIDTH-1:0] ramaddress;
  logic [WIDTH-1:0] writeramdata;
  logic [WIDTH-1:0] readramdata;
  logic [7:0]       stream_data;
  logic             stream_valid;
  logic             stream_ready;

  modport slave (
    input  writeram, ramaddress, writeramdata, stream_ready,
    output readramdata, stream_data, stream_valid
  );

  modport master (
    output writeram, ramaddress, writeramdata, stream_ready,
    input  readramdata, stream_data, stream_valid
  );
endinterface

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - data RAM, output byte FIFO, STATUS and CYCLES for the core
//
// Purpose: answers the core's never-stalling data-RAM port. Reads are
//          combinational from current state; writes commit at posedge clk.
//          Holds the word RAM, a byte FIFO feeding the encoded stream sink,
//          a STATUS register (count/ovf/full/empty) and a cycle counter.
// Ports:
//   clk   in  clock, all state on rising edge
//   nrst  in  asynchronous active-low reset
//   bus   data_bus_responder_if.slave (RAM port + stream valid/ready)
// Address map: addr[31]=0 RAM (aliased on word index), addr[31]=1 registers
//   on addr[3:2]: 00 TXDATA, 01 STATUS, 10 CYCLES, 11 reserved.
`timescale 1ns/1ps

module data_bus_responder #(
  parameter int WIDTH     = 32,
  parameter int RAMWORDS  = 1024,
  parameter int FIFODEPTH = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  data_bus_responder_if.slave   bus
);

  localparam int AW = $clog2(RAMWORDS);
  localparam int PW = $clog2(FIFODEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFODEPTH);

  localparam logic [1:0] REG_TXDATA = 2'b00;
  localparam logic [1:0] REG_STATUS = 2'b01;
  localparam logic [1:0] REG_CYCLES = 2'b10;

  // Storage arrays carry no reset: contents are undefined until written.
  logic [WIDTH-1:0] ram_q  [RAMWORDS];
  logic [7:0]       fifo_q [FIFODEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cycles_q, cycles_d;

  logic          is_periph;
  logic [1:0]    reg_sel;
  logic [AW-1:0] word_idx;
  logic          ram_we;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          ovf_clr;
  logic          empty;
  logic          full;
  logic [31:0]   status;

  // Address bits the decode deliberately ignores (RAM aliasing, byte offset).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ramaddress[WIDTH-2:AW+2], bus.ramaddress[1:0]};

  always_comb begin
    is_periph = bus.ramaddress[WIDTH-1];
    reg_sel   = bus.ramaddress[3:2];
    word_idx  = bus.ramaddress[AW+1:2];

    ram_we    = bus.writeram & ~is_periph;
    push_req  = bus.writeram & is_periph & (reg_sel == REG_TXDATA);
    ovf_clr   = bus.writeram & is_periph & (reg_sel == REG_STATUS) & bus.writeramdata[2];

    empty     = (count_q == '0);
    full      = (count_q == DEPTH);
    pop       = ~empty & bus.stream_ready;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    push_ok   = push_req & (~full | pop);

    wr_ptr_d  = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push_ok) - CW'(pop);
    // Overflow set takes priority over a simultaneous clear.
    ovf_d     = (push_req & ~push_ok) | (ovf_q & ~ovf_clr);
    cycles_d  = cycles_q + 32'd1;

    status    = {16'b0, 8'(count_q), 5'b0, ovf_q, full, empty};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cycles_q <= cycles_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[word_idx] <= bus.writeramdata;
    end
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= bus.writeramdata[7:0];
    end
  end

  // Stream outputs come only from registered state: no push-to-valid bypass.
  assign bus.stream_valid = ~empty;
  assign bus.stream_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

  always_comb begin
    bus.readramdata = '0;
    if (!is_periph) begin
      bus.readramdata = ram_q[word_idx];
    end else begin
      case (reg_sel)
        REG_STATUS: bus.readramdata = status;
        REG_CYCLES: bus.readramdata = cycles_q;
        default:    bus.readramdata = '0;
      endcase
    end
  end

endmodule
